// File: rtl/iterative_alu_if.sv
// Request/response bundle for the iterative ALU.
//
// Handshake: a transfer happens on a rising clk edge where valid && ready
// are both high. The sender holds its payload stable while valid is high and
// ready is low; the receiver may raise or lower ready at any time.
//   request  channel: in_valid / in_ready   payload ALUControl, SrcA, SrcB
//   response channel: out_valid / out_ready payload ALUResult, Zero
//
// Modports:
//   master - requester/consumer (drives request payload and out_ready)
//   slave  - the ALU (drives in_ready and the response payload)
interface iterative_alu_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       ALUControl;
    logic [WIDTH-1:0] SrcA;
    logic [WIDTH-1:0] SrcB;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] ALUResult;
    logic             Zero;

    modport master (
        output in_valid, ALUControl, SrcA, SrcB, out_ready,
        input  in_ready, out_valid, ALUResult, Zero
    );

    modport slave (
        input  in_valid, ALUControl, SrcA, SrcB, out_ready,
        output in_ready, out_valid, ALUResult, Zero
    );
endinterface

// File: rtl/iterative_alu.sv
// Multi-cycle ALU with a valid/ready request and response channel.
// Non-shift operations finish in one cycle. Shifts move one bit per cycle,
// so a shift by N takes max(1,N) cycles, unless ITERATIVE_ALU_FAST_SHIFT_EN
// is defined, in which case a barrel shifter finishes every shift in one
// cycle and the SHIFT state is never entered.
//
// Ports:
//   clk       - clock, rising edge
//   rst_n     - asynchronous active-low reset
//   bus       - iterative_alu_if.slave (request in, registered result out)
//   dbg_state - current FSM state (0 IDLE, 1 SHIFT, 2 DONE)
//
// Opcodes: 0 add, 1 sub, 2 and, 3 or, 4 sll, 5 slt, 6 srl, 7 sra, 8 sge,
// 9 xor, anything else returns 0.
module iterative_alu #(
    parameter int WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    iterative_alu_if.slave        bus,
    output logic [1:0]            dbg_state
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] acc;
    logic [4:0]       cnt;
    logic [3:0]       op;

    logic             accept;
    logic [4:0]       amt;
    logic             is_iter;
    logic [WIDTH-1:0] comb_res;

    function automatic logic is_shift(input logic [3:0] c);
        return (c == 4'b0100) || (c == 4'b0110) || (c == 4'b0111);
    endfunction

    // Single-bit step used by the iterative shifter.
    function automatic logic [WIDTH-1:0] shift1(input logic [WIDTH-1:0] v,
                                                input logic [3:0] c);
        case (c)
            4'b0100: return {v[WIDTH-2:0], 1'b0};
            4'b0110: return {1'b0, v[WIDTH-1:1]};
            4'b0111: return {v[WIDTH-1], v[WIDTH-1:1]};
            default: return v;
        endcase
    endfunction

    function automatic logic [WIDTH-1:0] alu_op(input logic [3:0] c,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
        case (c)
            4'b0000: return a + b;
            4'b0001: return a - b;
            4'b0010: return a & b;
            4'b0011: return a | b;
            4'b0101: return {{(WIDTH-1){1'b0}}, ($signed(a) <  $signed(b))};
            4'b1000: return {{(WIDTH-1){1'b0}}, ($signed(a) >= $signed(b))};
            4'b1001: return a ^ b;
`ifdef ITERATIVE_ALU_FAST_SHIFT_EN
            4'b0100: return a << b[4:0];
            4'b0110: return a >> b[4:0];
            4'b0111: return $unsigned($signed(a) >>> b[4:0]);
`else
            // Only reached for a shift by 0; non-zero amounts go iterative.
            4'b0100, 4'b0110, 4'b0111: return a;
`endif
            default: return '0;
        endcase
    endfunction

    assign accept   = (state == IDLE) && bus.in_valid;
    assign amt      = bus.SrcB[4:0];
    assign comb_res = alu_op(bus.ALUControl, bus.SrcA, bus.SrcB);
`ifdef ITERATIVE_ALU_FAST_SHIFT_EN
    assign is_iter  = 1'b0;
`else
    assign is_iter  = is_shift(bus.ALUControl) && (amt != 5'd0);
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state logic. cnt holds the shifts still to do after the current
    // edge, so cnt==1 in SHIFT means this edge performs the last one.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = (is_iter && amt > 5'd1) ? SHIFT : DONE;
            SHIFT:   if (cnt == 5'd1) state_nx = DONE;
            DONE:    if (bus.out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        bus.in_ready  = (state == IDLE);
        bus.out_valid = (state == DONE);
        dbg_state     = state;
    end

    // Datapath: accumulator doubles as the result register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            cnt <= '0;
            op  <= '0;
        end else if (accept) begin
            op <= bus.ALUControl;
            if (is_iter) begin
                acc <= shift1(bus.SrcA, bus.ALUControl);
                cnt <= amt - 5'd1;
            end else begin
                acc <= comb_res;
                cnt <= '0;
            end
        end else if (state == SHIFT) begin
            acc <= shift1(acc, op);
            cnt <= cnt - 5'd1;
        end
    end

    assign bus.ALUResult = acc;
    assign bus.Zero      = (acc == '0);
endmodule

// File: doc/iterative_alu.md
ITERATIVE_ALU -- requirements
Module: iterative_alu

Interface
- REQ-001 Parameter WIDTH, default 32: datapath width in bits; only 32 is supported.
- REQ-002 clk, input, 1: single clock; all state updates on rising edge.
- REQ-003 rst_n, input, 1: reset, asynchronous and active-low.
- REQ-004 in_valid, input, 1: operation request valid.
- REQ-005 in_ready, output, 1: unit can accept a request.
- REQ-006 ALUControl, input, 4: operation code, same encoding the decoder drives.
- REQ-007 SrcA, input, WIDTH: operand A.
- REQ-008 SrcB, input, WIDTH: operand B; for shifts, SrcB[4:0] is the shift amount and SrcB[31:5] is ignored.
- REQ-009 out_valid, output, 1: ALUResult and Zero are valid.
- REQ-010 out_ready, input, 1: consumer accepts the result.
- REQ-011 ALUResult, output, WIDTH: registered result.
- REQ-012 Zero, output, 1: high when ALUResult == 0.

Function
- REQ-013 The codes SHALL be: 0000 add; 0001 sub; 0010 and; 0011 or; 0100 sll; 0101 slt (signed, result 0 or 1); 0110 srl; 0111 sra; 1000 sge (signed SrcA >= SrcB, result 0 or 1); 1001 xor; any other code gives result 0.
- REQ-014 add/sub SHALL wrap modulo 2^32, with no carry or overflow output.
- REQ-015 The FSM SHALL have states IDLE, SHIFT and DONE; in_ready = 1 only in IDLE, and out_valid = 1 only in DONE.
- REQ-016 A request is accepted on a rising edge where in_valid && in_ready; ALUControl, SrcA and SrcB are sampled only at that edge.
- REQ-017 A non-shift op, or a shift with amount 0, SHALL go IDLE->DONE at the accept edge, giving latency 1; a shift by 0 returns SrcA unchanged.
- REQ-018 A shift with amount N>0 SHALL register SrcA shifted by 1 and a count of N-1 at the accept edge.
- REQ-019 For that shift, the FSM SHALL enter DONE if N==1, otherwise SHIFT.
- REQ-020 In SHIFT, each edge SHALL shift the accumulator by 1 bit: sll fills with 0, srl fills with 0, sra fills with the sign bit.
- REQ-021 In SHIFT, each edge SHALL decrement the count, and the FSM SHALL move to DONE on the edge where the count reaches 0; shift latency is max(1,N) cycles.
- REQ-022 In DONE, ALUResult and Zero SHALL stay stable until out_ready is high.
- REQ-023 On an edge with out_valid && out_ready, the FSM SHALL return to IDLE; the next accept is possible no earlier than the following edge (no same-cycle overlap).
- REQ-024 in_valid while the FSM is not in IDLE SHALL be ignored and SHALL not disturb the operation in flight.
- REQ-025 Zero SHALL be computed from the registered result; it holds no state of its own.

Reset
- REQ-026 While rst_n = 0, the FSM SHALL be IDLE, in_ready = 1, out_valid = 0, ALUResult = 0, Zero = 1 and the count = 0.
- REQ-027 Reset asserted mid-SHIFT or mid-DONE SHALL abort the operation immediately, with no result delivered.
- REQ-028 After reset release, the first accept is possible on the first rising edge.

Configuration
- REQ-029 Macro ITERATIVE_ALU_FAST_SHIFT_EN defined: all shifts SHALL complete in one cycle via a barrel shifter, giving latency 1 for every op; the SHIFT state is unreachable.
- REQ-030 ITERATIVE_ALU_FAST_SHIFT_EN undefined: shifts SHALL be iterative per REQ-018..REQ-021.
- REQ-031 The handshake, reset values and non-shift behaviour SHALL be identical in both builds.

Verification
- REQ-032 Code 0001, A=5, B=5, out_ready=1 -> out_valid one cycle after accept, ALUResult=0, Zero=1, in_ready=1 on the next cycle.
- REQ-033 Code 0111, A=0x80000000, B=4 -> iterative build: out_valid 4 cycles after accept, ALUResult=0xF8000000; fast build: 1 cycle, same value.
- REQ-034 Code 0100, A=1, B=0x25 (amount 5) -> ALUResult=0x20, latency 5; B=0 -> ALUResult=1, latency 1.
- REQ-035 Code 0101, A=0xFFFFFFFF, B=1, out_ready held 0 for 3 cycles -> ALUResult=1 stable and in_ready=0 throughout, release on out_ready=1.
- REQ-036 Start 0110, A=0xF0, B=31, assert rst_n=0 at cycle 10 -> out_valid=0 and in_ready=1 immediately, no result delivered; a new 0000 request A=2, B=3 after release -> 5.
- REQ-037 Code 1100, A=7, B=9 -> ALUResult=0, Zero=1, latency 1.
